logmap_core: RTL and testbench

Fixed-point logistic-map iterator, x(n+1) = r·x(n)·(1 − x(n)). It sits directly behind the logmapAXI S00_AXI register bank. The bank supplies r, x0, the iteration count and a start strobe; this block returns busy/done status to the bank. Iterates are streamed out on an AXI4-Stream master port with full backpressure.

---
 rtl/logmap_pkg.sv | 19 +
 rtl/logmap_step.sv | 46 ++++
 rtl/logmap_core.sv | 127 ++++++++++++
 tb/tb_logmap_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/logmap_pkg.sv
// Shared types and Q-format constants for the fixed-point logistic-map iterator.
// r is unsigned Q3.29; x is unsigned Q0.32 in [0,1).
package logmap_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned R_FRAC     = 29;
   localparam int unsigned CNT_WIDTH  = 16;

   localparam logic [DATA_WIDTH-1:0] R_ONE  = DATA_WIDTH'(1) << R_FRAC;
   localparam logic [DATA_WIDTH-1:0] X_HALF = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL1 = 2'd1,
      MUL2 = 2'd2,
      EMIT = 2'd3
   } state_t;

endpackage

// File: rtl/logmap_step.sv
// Two registered datapath stages of one logistic-map step:
// stage 1 p = x*(1-x), stage 2 y = r*p with saturation to all-ones.
module logmap_step #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned R_FRAC     = 29
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_en1,
   input  logic                  i_en2,
   input  logic [DATA_WIDTH-1:0] i_x,
   input  logic [DATA_WIDTH-1:0] i_r,
   output logic [DATA_WIDTH-1:0] o_y
);

   logic [DATA_WIDTH:0]     w_omx;
   logic [2*DATA_WIDTH:0]   w_prod1;
   logic [DATA_WIDTH-1:0]   w_p;
   logic [2*DATA_WIDTH-1:0] w_prod2;
   logic [2*DATA_WIDTH-1:0] w_y_full;
   logic [DATA_WIDTH-1:0]   w_y_sat;
   logic [DATA_WIDTH-1:0]   r_p;
   logic [DATA_WIDTH-1:0]   r_y;

   // 1 - x as an integer is 2^DATA_WIDTH - x, which needs one extra bit when x is 0
   assign w_omx    = {1'b1, {DATA_WIDTH{1'b0}}} - {1'b0, i_x};
   assign w_prod1  = {{(DATA_WIDTH + 1){1'b0}}, i_x} * {{DATA_WIDTH{1'b0}}, w_omx};
   assign w_p      = DATA_WIDTH'(w_prod1 >> DATA_WIDTH);

   assign w_prod2  = {{DATA_WIDTH{1'b0}}, i_r} * {{DATA_WIDTH{1'b0}}, r_p};
   assign w_y_full = w_prod2 >> R_FRAC;
   assign w_y_sat  = (|w_y_full[2*DATA_WIDTH-1:DATA_WIDTH]) ? '1 : w_y_full[DATA_WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p <= '0;
         r_y <= '0;
      end else begin
         if (i_en1) r_p <= w_p;
         if (i_en2) r_y <= w_y_sat;
      end
   end

   assign o_y = r_y;

endmodule

// File: rtl/logmap_core.sv
// Logistic-map iterator x(n+1) = r*x(n)*(1-x(n)) with an AXI4-Stream master output.
// Owns the control FSM, iteration counter, operand latches and stream handshake.
module logmap_core
   import logmap_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = logmap_pkg::DATA_WIDTH,
   parameter int unsigned R_FRAC     = logmap_pkg::R_FRAC,
   parameter int unsigned CNT_WIDTH  = logmap_pkg::CNT_WIDTH
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] r_in,
   input  logic [DATA_WIDTH-1:0] x0_in,
   input  logic [CNT_WIDTH-1:0]  n_iter,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast
);

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_x;
   logic [DATA_WIDTH-1:0] r_r;
   logic [CNT_WIDTH-1:0]  r_n;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_tvalid;
   logic                  r_tlast;

   logic                  w_en1;
   logic                  w_en2;
   logic                  w_last;
   logic                  w_hs;
   logic [DATA_WIDTH-1:0] w_y;

   assign w_en1  = (r_state == MUL1) && !abort;
   assign w_en2  = (r_state == MUL2) && !abort;
   assign w_last = (r_cnt == (r_n - CNT_WIDTH'(1)));
   assign w_hs   = r_tvalid && m_tready;

   logmap_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .R_FRAC     (R_FRAC)
   ) u_step (
      .clk   (ACLK),
      .rst   (ARESET),
      .i_en1 (w_en1),
      .i_en2 (w_en2),
      .i_x   (r_x),
      .i_r   (r_r),
      .o_y   (w_y)
   );

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state  <= IDLE;
         r_x      <= '0;
         r_r      <= '0;
         r_n      <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // abort overrides everything, including a coincident final handshake
         if (abort) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     if (n_iter != '0) begin
                        r_r     <= r_in;
                        r_x     <= x0_in;
                        r_n     <= n_iter;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MUL1;
                     end else begin
                        r_done <= 1'b1;
                     end
                  end
               end
               MUL1: r_state <= MUL2;
               MUL2: begin
                  r_tlast  <= w_last;
                  r_tvalid <= 1'b1;
                  r_state  <= EMIT;
               end
               EMIT: begin
                  if (w_hs) begin
                     r_tvalid <= 1'b0;
                     r_tlast  <= 1'b0;
                     if (r_tlast) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                     end else begin
                        r_x     <= w_y;
                        r_cnt   <= r_cnt + CNT_WIDTH'(1);
                        r_state <= MUL1;
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign m_tdata  = w_y;
   assign m_tvalid = r_tvalid;
   assign m_tlast  = r_tlast;

endmodule

// File: tb/tb_logmap_core.sv
// Directed and randomized bench for logmap_core against a plain-arithmetic
// model of the logistic map (64-bit integer maths, truncation, saturation).
module tb_logmap_core;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] r_in = '0;
   logic [31:0] x0_in = '0;
   logic [15:0] n_iter = '0;
   logic        busy;
   logic        done;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic        m_tlast;

   int checks = 0;
   int errors = 0;

   logmap_core #(
      .DATA_WIDTH (32),
      .R_FRAC     (29),
      .CNT_WIDTH  (16)
   ) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .start    (start),
      .abort    (abort),
      .r_in     (r_in),
      .x0_in    (x0_in),
      .n_iter   (n_iter),
      .busy     (busy),
      .done     (done),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // x' = floor(r * floor(x*(2^32-x) / 2^32) / 2^29), clipped at 2^32-1
   function automatic logic [31:0] model_step(input logic [31:0] r, input logic [31:0] x);
      longint unsigned xx, p, y;
      xx = 64'(x);
      p  = (xx * (64'h1_0000_0000 - xx)) >> 32;
      y  = (64'(r) * p) >> 29;
      if (y > 64'h0000_0000_FFFF_FFFF) y = 64'h0000_0000_FFFF_FFFF;
      return y[31:0];
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},   64'(busy),     64'd0);
      check({tag, "_done"},   64'(done),     64'd0);
      check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
      check({tag, "_tlast"},  64'(m_tlast),  64'd0);
   endtask

   // mode 0: ready held high; 1: random ready; 2: 10-cycle stall on beat 2.
   // restart: pulse start with other operands while the run is active.
   task automatic do_run(input string tag, input logic [31:0] r, input logic [31:0] x0,
                         input logic [15:0] n, input int mode, input bit restart);
      logic [31:0] exp_q[$];
      logic [31:0] x, held;
      int beat, c, first, last_hs, stall;
      bit pending;
      x = x0;
      for (int i = 0; i < int'(n); i++) begin
         x = model_step(r, x);
         exp_q.push_back(x);
      end
      @(negedge ACLK);
      r_in = r; x0_in = x0; n_iter = n; start = 1'b1;
      m_tready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      beat = 0; c = 0; first = 0; last_hs = 0; stall = 0; pending = 1'b0; held = '0;
      while (beat < int'(n) && c < 64 + 40 * int'(n)) begin
         @(negedge ACLK);
         c++;
         start = 1'b0;
         if (restart && c == 4) begin
            start = 1'b1; r_in = ~r; x0_in = x0 ^ 32'h1234_5678; n_iter = n + 16'd3;
         end
         check({tag, "_busy"}, 64'(busy), 64'd1);
         check({tag, "_nodone"}, 64'(done), 64'd0);
         if (pending) begin
            check({tag, "_hold_valid"}, 64'(m_tvalid), 64'd1);
            check({tag, "_hold_data"}, 64'(m_tdata), 64'(held));
            check({tag, "_hold_last"}, 64'(m_tlast), 64'(beat == int'(n) - 1));
         end
         pending = 1'b0;
         if (m_tvalid) begin
            if (first == 0) begin
               first = c;
               check({tag, "_latency"}, 64'(first), 64'd3);
            end
            case (mode)
               0: m_tready = 1'b1;
               1: m_tready = 1'($urandom_range(0, 1));
               default: begin
                  if (beat == 1 && stall < 10) begin
                     m_tready = 1'b0;
                     stall++;
                  end else begin
                     m_tready = 1'b1;
                  end
               end
            endcase
            if (m_tready) begin
               check({tag, "_data"}, 64'(m_tdata), 64'(exp_q[beat]));
               check({tag, "_tlast"}, 64'(m_tlast), 64'(beat == int'(n) - 1));
               if (mode == 0 && beat > 0) check({tag, "_spacing"}, 64'(c - last_hs), 64'd3);
               last_hs = c;
               beat++;
            end else begin
               pending = 1'b1;
               held = m_tdata;
            end
         end else if (mode == 1) begin
            m_tready = 1'($urandom_range(0, 1));
         end
      end
      check({tag, "_beats"}, 64'(beat), 64'(n));
      if (mode == 2) check({tag, "_stalls"}, 64'(stall), 64'd10);
      @(negedge ACLK);
      m_tready = 1'b0;
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
      check({tag, "_tvalid_end"}, 64'(m_tvalid), 64'd0);
      @(negedge ACLK);
      check({tag, "_done_once"}, 64'(done), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      // reset state while ARESET is held
      #12;
      check_idle_outputs("reset");
      check("reset_tdata", 64'(m_tdata), 64'd0);
      @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      check_idle_outputs("post_reset");

      do_run("fixed_point", 32'h4000_0000, 32'h8000_0000, 16'd4, 0, 1'b0);
      do_run("saturate",    32'h8000_0000, 32'h8000_0000, 16'd3, 0, 1'b0);
      do_run("midrange",    32'h6000_0000, 32'h4000_0000, 16'd1, 0, 1'b0);
      do_run("backpress",   32'h4000_0000, 32'h8000_0000, 16'd4, 2, 1'b0);

      // zero-count start: done next cycle, no beats
      @(negedge ACLK);
      n_iter = 16'd0; r_in = 32'h4000_0000; x0_in = 32'h8000_0000; start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
      check("zero_done", 64'(done), 64'd1);
      check("zero_tvalid", 64'(m_tvalid), 64'd0);
      check("zero_busy", 64'(busy), 64'd0);
      @(negedge ACLK);
      check("zero_done_once", 64'(done), 64'd0);
      check("zero_tvalid2", 64'(m_tvalid), 64'd0);

      do_run("restart_ign", 32'h7000_0000, 32'h3000_0000, 16'd5, 0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         do_run("random", $urandom, $urandom, 16'($urandom_range(1, 5)), 1, 1'b0);
      end

      // abort coincident with the final (tlast) handshake
      @(negedge ACLK);
      r_in = 32'h4000_0000; x0_in = 32'h8000_0000; n_iter = 16'd1; start = 1'b1; m_tready = 1'b0;
      for (int i = 0; i < 10 && !(i > 0 && m_tvalid); i++) begin
         @(negedge ACLK);
         start = 1'b0;
      end
      check("abort_reach_emit", 64'(m_tvalid), 64'd1);
      check("abort_tlast_set", 64'(m_tlast), 64'd1);
      abort = 1'b1; m_tready = 1'b1;
      @(negedge ACLK);
      abort = 1'b0; m_tready = 1'b0;
      check_idle_outputs("abort");
      @(negedge ACLK);
      check_idle_outputs("abort_after");

      // asynchronous reset while in MUL2
      @(negedge ACLK);
      r_in = 32'h6000_0000; x0_in = 32'h4000_0000; n_iter = 16'd3; start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
      @(negedge ACLK);
      check("mul2_busy", 64'(busy), 64'd1);
      check("mul2_tdata_stale", 64'(m_tdata), 64'h8000_0000);
      #1 ARESET = 1'b1;
      #1;
      check_idle_outputs("async_reset");
      check("async_reset_tdata", 64'(m_tdata), 64'd0);
      @(negedge ACLK);
      ARESET = 1'b0;

      do_run("post_rst_run", 32'h6000_0000, 32'h4000_0000, 16'd1, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
